// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//  Write-side driver for the 32x64 register file. It collects ALU and load results
//  into an in-order queue and retires at most one write per cycle on RegWr/RW/BusW.
//  Values that are pending (queued or in the output stage) are forwarded to the
//  decode read ports. Writes to X31 (XZR) are discarded.
// Ports
//  Clk, Reset_n               clock, async active-low reset
//  AluValid/AluRd/AluData     ALU result
//  MemValid/MemRd/MemData     load result (older than the ALU result in the same cycle)
//  InReady                    room for two entries this cycle
//  RegWr/RW/BusW              registered register-file write port
//  RA, RB                     decode read addresses
//  FwdA*/FwdB*                youngest pending value for RA/RB
//  Overflow                   sticky: a valid input was dropped
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             AluValid,
  input  logic [4:0]       AluRd,
  input  logic [WIDTH-1:0] AluData,
  input  logic             MemValid,
  input  logic [4:0]       MemRd,
  input  logic [WIDTH-1:0] MemData,
  output logic             InReady,
  output logic             RegWr,
  output logic [4:0]       RW,
  output logic [WIDTH-1:0] BusW,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  output logic             FwdAValid,
  output logic [WIDTH-1:0] FwdAData,
  output logic             FwdBValid,
  output logic [WIDTH-1:0] FwdBData,
  output logic             Overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]       r_q_rd   [DEPTH];
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_regwr, r_ovf;
  logic [4:0]       r_rw;
  logic [WIDTH-1:0] r_busw;

  logic          w_mem_ok, w_alu_ok, w_enq_mem, w_enq_alu, w_deq;
  logic [CW-1:0] w_enq_cnt;

  // XZR writes are not real inputs: never queued, never counted as drops
  assign w_mem_ok  = MemValid && (MemRd != 5'd31);
  assign w_alu_ok  = AluValid && (AluRd != 5'd31);
  // Pre-update count only: a same-cycle pop does not open slots
  assign InReady   = (r_count <= CW'(DEPTH - 2));
  assign w_enq_mem = w_mem_ok && InReady;
  assign w_enq_alu = w_alu_ok && InReady;
  assign w_enq_cnt = CW'(w_enq_mem) + CW'(w_enq_alu);
  assign w_deq     = (r_count != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_rd[i]   <= '0;
        r_q_data[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_regwr  <= 1'b0;
      r_rw     <= '0;
      r_busw   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // Mem entry takes the first slot so it retires before the ALU entry
      if (w_enq_mem) begin
        r_q_rd[r_wr_ptr]   <= MemRd;
        r_q_data[r_wr_ptr] <= MemData;
      end
      if (w_enq_alu) begin
        r_q_rd[r_wr_ptr + PW'(w_enq_mem)]   <= AluRd;
        r_q_data[r_wr_ptr + PW'(w_enq_mem)] <= AluData;
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_enq_cnt);

      // RW/BusW hold when idle; only the strobe drops
      r_regwr <= w_deq;
      if (w_deq) begin
        r_rw     <= r_q_rd[r_rd_ptr];
        r_busw   <= r_q_data[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      r_count <= r_count + w_enq_cnt - CW'(w_deq);

      if (!InReady && (w_mem_ok || w_alu_ok)) r_ovf <= 1'b1;
    end
  end

  assign RegWr    = r_regwr;
  assign RW       = r_rw;
  assign BusW     = r_busw;
  assign Overflow = r_ovf;

  // Forwarding: output stage is the oldest candidate, then queue entries from
  // head (oldest) to tail; later hits overwrite so the youngest wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    FwdAValid = 1'b0;
    FwdAData  = '0;
    FwdBValid = 1'b0;
    FwdBData  = '0;
    if (r_regwr && (r_rw == RA)) begin
      FwdAValid = 1'b1;
      FwdAData  = r_busw;
    end
    if (r_regwr && (r_rw == RB)) begin
      FwdBValid = 1'b1;
      FwdBData  = r_busw;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rd_ptr + PW'(k);
      if (CW'(k) < r_count) begin
        if (r_q_rd[idx] == RA) begin
          FwdAValid = 1'b1;
          FwdAData  = r_q_data[idx];
        end
        if (r_q_rd[idx] == RB) begin
          FwdBValid = 1'b1;
          FwdBData  = r_q_data[idx];
        end
      end
    end
    if (RA == 5'd31) begin
      FwdAValid = 1'b0;
      FwdAData  = '0;
    end
    if (RB == 5'd31) begin
      FwdBValid = 1'b0;
      FwdBData  = '0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;
  localparam int W = 64;

  logic         Clk, Reset_n;
  logic         AluValid, MemValid;
  logic [4:0]   AluRd, MemRd, RA, RB;
  logic [W-1:0] AluData, MemData;
  logic         InReady, RegWr, FwdAValid, FwdBValid, Overflow;
  logic [4:0]   RW;
  logic [W-1:0] BusW, FwdAData, FwdBData;

  int n_chk = 0;
  int n_fail = 0;

  // register-file model: samples on negedge, logs every retired write
  logic [W-1:0] rf [32];
  logic [4:0]   lrd [$];
  logic [W-1:0] ldat [$];

  regfile_writeback_queue #(.DEPTH(4), .WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData),
    .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData),
    .InReady(InReady), .RegWr(RegWr), .RW(RW), .BusW(BusW),
    .RA(RA), .RB(RB),
    .FwdAValid(FwdAValid), .FwdAData(FwdAData),
    .FwdBValid(FwdBValid), .FwdBData(FwdBData),
    .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (RegWr) begin
      rf[RW] <= BusW;
      lrd.push_back(RW);
      ldat.push_back(BusW);
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    AluValid = 1'b0; MemValid = 1'b0;
    AluRd = '0; MemRd = '0; AluData = '0; MemData = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    idle_in();
    RA = '0; RB = '0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst RegWr", RegWr, 0);
    chk("rst RW", RW, 0);
    chk("rst BusW", BusW, 0);
    chk("rst Overflow", Overflow, 0);
    chk("rst InReady", InReady, 1);
    chk("rst FwdAValid", FwdAValid, 0);
    Reset_n = 1'b1;
    step();

    // 1: single ALU write, one-cycle latency
    AluValid = 1; AluRd = 5; AluData = 64'hA5; RA = 5;
    step();
    idle_in();
    chk("t1 RegWr k", RegWr, 0);
    chk("t1 fwd valid", FwdAValid, 1);
    chk("t1 fwd data", FwdAData, 64'hA5);
    step();
    chk("t1 RegWr k+1", RegWr, 1);
    chk("t1 RW", RW, 5);
    chk("t1 BusW", BusW, 64'hA5);
    step();
    chk("t1 RegWr k+2", RegWr, 0);
    chk("t1 X5", rf[5], 64'hA5);

    // 2: dual valid, same Rd; Mem older
    AluValid = 1; AluRd = 3; AluData = 1;
    MemValid = 1; MemRd = 3; MemData = 2; RA = 3;
    step();
    idle_in();
    chk("t2 fwd both pend", FwdAData, 1);
    chk("t2 fwd v", FwdAValid, 1);
    step();
    chk("t2 w1 RegWr", RegWr, 1);
    chk("t2 w1 BusW", BusW, 2);
    chk("t2 fwd q beats out", FwdAData, 1);
    step();
    chk("t2 w2 RegWr", RegWr, 1);
    chk("t2 w2 BusW", BusW, 1);
    step();
    chk("t2 idle", RegWr, 0);
    chk("t2 X3", rf[3], 1);

    // 3: XZR discarded
    AluValid = 1; AluRd = 31; AluData = 64'hFF; RA = 31;
    step();
    idle_in();
    chk("t3 fwd31", FwdAValid, 0);
    chk("t3 InReady", InReady, 1);
    step();
    chk("t3 no RegWr", RegWr, 0);
    step();
    chk("t3 no RegWr 2", RegWr, 0);

    // 4: fill to count=3, then drop
    lrd.delete(); ldat.delete();
    RA = 0;
    MemValid = 1; MemRd = 1; MemData = 64'h11;
    AluValid = 1; AluRd = 2; AluData = 64'h12;
    step();
    chk("t4 ready c2", InReady, 1);
    MemRd = 3; MemData = 64'h13; AluRd = 4; AluData = 64'h14;
    step();
    chk("t4 ready c3", InReady, 0);
    chk("t4 ovf before", Overflow, 0);
    MemRd = 6; MemData = 64'h66; AluRd = 8; AluData = 64'h68;
    step();
    idle_in();
    chk("t4 ovf", Overflow, 1);
    repeat (8) step();
    chk("t4 nwrites", lrd.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t4 rd", (i < lrd.size()) ? W'(lrd[i]) : 64'hDEAD, W'(i + 1));
      chk("t4 data", (i < ldat.size()) ? ldat[i] : 64'hDEAD, 64'h11 + W'(i));
    end
    chk("t4 ovf sticky", Overflow, 1);

    // 5: two pending X7 values, youngest forwarded
    MemValid = 1; MemRd = 7; MemData = 64'h10;
    AluValid = 1; AluRd = 7; AluData = 64'h20; RA = 7; RB = 7;
    chk("t5 same-cycle no fwd", FwdAValid, 0);
    step();
    idle_in();
    chk("t5 fwdA", FwdAData, 64'h20);
    chk("t5 fwdB", FwdBData, 64'h20);
    step();
    chk("t5 fwdA out+q", FwdAData, 64'h20);
    step();
    chk("t5 fwdA out", FwdAData, 64'h20);
    chk("t5 fwdB v out", FwdBValid, 1);
    step();
    chk("t5 fwdA gone", FwdAValid, 0);
    chk("t5 X7", rf[7], 64'h20);

    // 6: async reset with entries queued
    MemValid = 1; MemRd = 9;  MemData = 64'h90;
    AluValid = 1; AluRd = 10; AluData = 64'hA0;
    step();
    MemRd = 11; MemData = 64'hB0; AluRd = 12; AluData = 64'hC0;
    step();
    idle_in();
    RA = 12;
    chk("t6 pre RegWr", RegWr, 1);
    chk("t6 pre ready", InReady, 0);
    lrd.delete(); ldat.delete();
    #2 Reset_n = 1'b0;
    #1;
    chk("t6 RegWr async", RegWr, 0);
    chk("t6 ready", InReady, 1);
    chk("t6 ovf clr", Overflow, 0);
    chk("t6 fwd clr", FwdAValid, 0);
    Reset_n = 1'b1;
    repeat (5) step();
    chk("t6 no writes", lrd.size(), 0);
    chk("t6 RegWr", RegWr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
